fwd_hazard_unit: RTL and testbench

- Produces the 2-bit select codes for the two EX-stage operand forwarding muxes (sel 00 = register file, 01 = WB result, 10 = MEM result).
- Raises the load-use stall.
- Keeps its own shadow copy of the destination-register info for the EX and MEM stages and advances it with the pipeline.
- Sits beside the ID/EX pipeline register. Its selects are registered so they arrive in the same cycle as the instruction they belong to.

---
 rtl/fwd_hazard_unit.sv | 177 +++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Generates the EX-stage operand forwarding selects and the load-use stall.
//   Keeps a shadow copy of the EX and MEM destination info (valid, rd,
//   regwrite, memread) that advances with the pipeline. Sits beside ID/EX;
//   the selects are registered so they line up with the instruction's EX cycle.
//
//   Select encoding: 2'b00 register file, 2'b01 WB result, 2'b10 MEM result.
//
// Optional build macro: FWD_STATS_EN adds saturating statistics counters
//   (stall_cnt, fwd_mem_cnt, fwd_wb_cnt). Without it those ports are absent.
//
// Ports:
//   Clk, Reset      pipeline clock (rising edge), async active-high reset
//   id_valid        ID holds a real instruction
//   id_rs, id_rt    ID source registers; id_uses_rt qualifies id_rt
//   id_rd           ID destination; id_regwrite / id_memread qualify it
//   flush           squash the ID instruction
//   fwd_a, fwd_b    registered operand selects, valid during EX
//   stall           combinational load-use stall
//   stall_cnt, fwd_mem_cnt, fwd_wb_cnt   (FWD_STATS_EN only)
// ---------------------------------------------------------------------------

// Per-operand compare: next select plus the raw EX rd match used by the stall.
module fwd_op_sel #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  logic                  ex_vld,
    input  logic                  ex_rw,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_vld,
    input  logic                  mem_rw,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic [1:0]            sel_nxt,
    output logic                  ex_match
);
    logic hit_ex, hit_mem;

    // r0 is hard-wired zero, so a write to it can never be a source.
    assign ex_match = use_src & (ex_rd != '0) & (ex_rd == src);
    assign hit_ex   = ex_match & ex_vld & ex_rw;
    assign hit_mem  = use_src & mem_vld & mem_rw & (mem_rd != '0) & (mem_rd == src);

    // EX is the newest producer, so it wins over MEM.
    always_comb begin
        sel_nxt = 2'b00;
        if (hit_ex)       sel_nxt = 2'b10;
        else if (hit_mem) sel_nxt = 2'b01;
    end
endmodule

module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
`ifdef FWD_STATS_EN
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_mem_cnt,
    output logic [CNT_W-1:0]      fwd_wb_cnt,
`endif
    output logic                  stall
);
    localparam int NUM_OPS = 2;  // [0] = operand A (rs), [1] = operand B (rt)

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } ex_info_t;

    // vld_pipe[0] = shadow EX valid, vld_pipe[1] = shadow MEM valid
    logic [1:0]                          vld_pipe;
    ex_info_t                            ex_q;
    logic [REG_ADDR_W-1:0]               mem_rd;
    logic                                mem_regwrite;
    logic [NUM_OPS-1:0][1:0]             fwd_q;

    logic [NUM_OPS-1:0][REG_ADDR_W-1:0]  srcs;
    logic [NUM_OPS-1:0]                  uses;
    logic [NUM_OPS-1:0][1:0]             sel_nxt;
    logic [NUM_OPS-1:0]                  ex_match;
    logic                                bubble;

    assign srcs = {id_rt, id_rs};
    assign uses = {id_uses_rt, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
            fwd_op_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
                .src      (srcs[gi]),
                .use_src  (uses[gi]),
                .ex_vld   (vld_pipe[0]),
                .ex_rw    (ex_q.regwrite),
                .ex_rd    (ex_q.rd),
                .mem_vld  (vld_pipe[1]),
                .mem_rw   (mem_regwrite),
                .mem_rd   (mem_rd),
                .sel_nxt  (sel_nxt[gi]),
                .ex_match (ex_match[gi])
            );
        end
    endgenerate

    // Load-use only depends on the EX load; a flushed ID instruction never stalls.
    // Reset clears vld_pipe asynchronously, so stall drops with it.
    assign stall  = id_valid & ~flush & vld_pipe[0] & ex_q.memread & (|ex_match);
    assign bubble = flush | stall;

    assign fwd_a = fwd_q[0];
    assign fwd_b = fwd_q[1];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_pipe     <= '0;
            ex_q         <= '0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            fwd_q        <= '0;
        end else begin
            // Shadow MEM never stalls.
            vld_pipe[1]  <= vld_pipe[0];
            mem_rd       <= ex_q.rd;
            mem_regwrite <= ex_q.regwrite;
            if (bubble) begin
                vld_pipe[0] <= 1'b0;
                ex_q        <= '0;
                fwd_q       <= '0;
            end else begin
                vld_pipe[0]  <= id_valid;
                ex_q.rd      <= id_valid ? id_rd : '0;
                ex_q.regwrite<= id_valid & id_regwrite;
                ex_q.memread <= id_valid & id_memread;
                fwd_q        <= id_valid ? sel_nxt : '0;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic ex_entry, any_mem, any_wb;

    // Both operands with the same select count once for that select.
    assign ex_entry = ~bubble & id_valid;
    assign any_mem  = (sel_nxt[0] == 2'b10) | (sel_nxt[1] == 2'b10);
    assign any_wb   = (sel_nxt[0] == 2'b01) | (sel_nxt[1] == 2'b01);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt   <= '0;
            fwd_mem_cnt <= '0;
            fwd_wb_cnt  <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (ex_entry && any_mem && fwd_mem_cnt != '1)
                fwd_mem_cnt <= fwd_mem_cnt + 1'b1;
            if (ex_entry && any_wb && fwd_wb_cnt != '1)
                fwd_wb_cnt <= fwd_wb_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Directed scenarios followed by random instruction streams, checked against
//   a model that keeps the last two issued slots and finds the newest producer
//   of each source by scanning them.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;
    localparam int W  = 5;
    localparam int CW = 16;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         id_valid, id_uses_rt, id_regwrite, id_memread, flush;
    logic [W-1:0] id_rs, id_rt, id_rd;
    logic [1:0]   fwd_a, fwd_b;
    logic         stall;
`ifdef FWD_STATS_EN
    logic [CW-1:0] stall_cnt, fwd_mem_cnt, fwd_wb_cnt;
`endif

    fwd_hazard_unit #(.REG_ADDR_W(W), .CNT_W(CW)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
`ifdef FWD_STATS_EN
        .stall_cnt   (stall_cnt),
        .fwd_mem_cnt (fwd_mem_cnt),
        .fwd_wb_cnt  (fwd_wb_cnt),
`endif
        .stall       (stall)
    );

    always #5 Clk = ~Clk;

    // Model: slot[0] is the instruction now in EX, slot[1] the one in MEM.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    ins_t slot [2];
    int   exp_fa, exp_fb;
    int   m_stall_cnt, m_mem_cnt, m_wb_cnt;
    int   vecs, errs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) slot[i] = '{v: 0, rd: 0, rw: 0, mr: 0};
        exp_fa = 0; exp_fb = 0;
        m_stall_cnt = 0; m_mem_cnt = 0; m_wb_cnt = 0;
    endtask

    // Newest earlier instruction that writes src decides the source.
    function automatic int src_sel(input int src);
        for (int d = 0; d < 2; d++)
            if (slot[d].v && slot[d].rw && slot[d].rd != 0 && slot[d].rd == src)
                return (d == 0) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        int r;
        r = slot[0].rd;
        return id_valid && !flush && slot[0].v && slot[0].mr && r != 0 &&
               (r == int'(id_rs) || (id_uses_rt && r == int'(id_rt)));
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit ut,
                         input int rd, input bit rw, input bit mr, input bit fl);
        id_valid = v; id_rs = W'(rs); id_rt = W'(rt); id_uses_rt = ut;
        id_rd = W'(rd); id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    // Called at a falling edge with inputs driven; checks, then clocks once.
    task automatic step();
        bit st;
        int nfa, nfb;
        #1;
        st = model_stall();
        chk("stall", 32'(stall), 32'(st));
        chk("fwd_a", 32'(fwd_a), exp_fa);
        chk("fwd_b", 32'(fwd_b), exp_fb);
`ifdef FWD_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), m_stall_cnt);
        chk("fwd_mem_cnt", 32'(fwd_mem_cnt), m_mem_cnt);
        chk("fwd_wb_cnt", 32'(fwd_wb_cnt), m_wb_cnt);
`endif
        nfa = id_valid ? src_sel(int'(id_rs)) : 0;
        nfb = (id_valid && id_uses_rt) ? src_sel(int'(id_rt)) : 0;
        @(posedge Clk);
        slot[1] = slot[0];
        if (st && m_stall_cnt < 65535) m_stall_cnt++;
        if (flush || st) begin
            slot[0] = '{v: 0, rd: 0, rw: 0, mr: 0};
            exp_fa = 0; exp_fb = 0;
        end else begin
            slot[0] = id_valid ? '{v: 1, rd: int'(id_rd), rw: id_regwrite, mr: id_memread}
                               : '{v: 0, rd: 0, rw: 0, mr: 0};
            exp_fa = nfa; exp_fb = nfb;
            if (id_valid && (nfa == 2 || nfb == 2) && m_mem_cnt < 65535) m_mem_cnt++;
            if (id_valid && (nfa == 1 || nfb == 1) && m_wb_cnt < 65535) m_wb_cnt++;
        end
        @(negedge Clk);
    endtask

    task automatic issue(input bit v, input int rs, input int rt, input bit ut,
                         input int rd, input bit rw, input bit mr, input bit fl);
        drive(v, rs, rt, ut, rd, rw, mr, fl);
        step();
    endtask

    initial begin
        vecs = 0; errs = 0;
        model_reset();
        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd_a", 32'(fwd_a), 0);
        chk("rst_fwd_b", 32'(fwd_b), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Back-to-back ALU dependence.
        issue(1, 1, 1, 1, 3, 1, 0, 0);      // add r3
        issue(1, 3, 4, 1, 6, 1, 0, 0);      // sub rs=3 rt=4
        chk("b2b_fwd_a", 32'(fwd_a), 2);
        chk("b2b_fwd_b", 32'(fwd_b), 0);

        // Distance-2 dependence on both operands.
        issue(1, 0, 0, 0, 5, 1, 0, 0);      // add r5
        issue(0, 0, 0, 0, 0, 0, 0, 0);      // nop
        issue(1, 5, 5, 1, 8, 1, 0, 0);      // or rs=5 rt=5
        chk("d2_fwd_a", 32'(fwd_a), 1);
        chk("d2_fwd_b", 32'(fwd_b), 1);

        // Double hit: newest producer wins.
        issue(1, 0, 0, 0, 7, 1, 0, 0);
        issue(1, 0, 0, 0, 7, 1, 0, 0);
        issue(1, 7, 0, 0, 9, 1, 0, 0);
        chk("prio_fwd_a", 32'(fwd_a), 2);

        // Load-use: one stall cycle, bubble, then WB forward.
        issue(1, 1, 0, 0, 2, 1, 1, 0);      // lw r2
        drive(1, 2, 9, 1, 10, 1, 0, 0);     // add rs=2
        #1 chk("lu_stall", 32'(stall), 1);
        step();
        chk("lu_bubble_a", 32'(fwd_a), 0);
        step();                              // same add retried
        chk("lu_fwd_a", 32'(fwd_a), 1);

        // r0 never forwards.
        issue(1, 0, 0, 0, 0, 1, 0, 0);      // add r0
        issue(1, 0, 0, 1, 11, 1, 0, 0);
        chk("r0_fwd_a", 32'(fwd_a), 0);
        chk("r0_fwd_b", 32'(fwd_b), 0);

        // Flush beats a load-use stall.
        issue(1, 1, 0, 0, 2, 1, 1, 0);      // lw r2
        drive(1, 2, 0, 0, 12, 1, 0, 1);
        #1 chk("fl_stall", 32'(stall), 0);
        step();
        chk("fl_bubble_a", 32'(fwd_a), 0);
        issue(1, 2, 0, 0, 13, 1, 0, 0);     // load now in MEM
        chk("fl_after_a", 32'(fwd_a), 1);

        // Reset in the middle of a stall.
        issue(1, 0, 0, 0, 3, 1, 0, 0);      // add r3
        issue(1, 3, 0, 0, 2, 1, 1, 0);      // lw r2 using r3
        chk("rs_pre_fwd_a", 32'(fwd_a), 2);
        drive(1, 2, 3, 1, 14, 1, 0, 0);
        #1 chk("rs_pre_stall", 32'(stall), 1);
        Reset = 1'b1;
        #1;
        chk("rs_async_stall", 32'(stall), 0);
        chk("rs_async_fwd_a", 32'(fwd_a), 0);
        chk("rs_async_fwd_b", 32'(fwd_b), 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        issue(1, 2, 3, 1, 14, 1, 0, 0);
        chk("rs_post_fwd_a", 32'(fwd_a), 0);
        chk("rs_post_fwd_b", 32'(fwd_b), 0);

        // Random streams over a small register window to provoke hazards.
        repeat (600) begin
            issue(($urandom % 8) != 0, $urandom % 6, $urandom % 6, $urandom % 2,
                  $urandom % 6, ($urandom % 4) != 0, ($urandom % 3) == 0,
                  ($urandom % 10) == 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
